demux_sel_sequencer: RTL and testbench



---
 rtl/demux_sel_sequencer_if.sv | 23 ++
 rtl/demux_sel_sequencer.sv | 106 ++++++++++
 tb/tb_demux_sel_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/demux_sel_sequencer_if.sv
// Bus between the demux select sequencer and its requester.
// DEMUX_SEQ_MASK_EN adds the ch_mask channel-enable field.
interface demux_sel_sequencer_if #(
  parameter int unsigned DWELL_W = 8
) ();
  logic               start;
  logic [DWELL_W-1:0] dwell;
`ifdef DEMUX_SEQ_MASK_EN
  logic [7:0]         ch_mask;
`endif
  logic [2:0]         sel;
  logic               strobe;
  logic               busy;
  logic               done;

`ifdef DEMUX_SEQ_MASK_EN
  modport master (output start, dwell, ch_mask, input sel, strobe, busy, done);
  modport slave  (input start, dwell, ch_mask, output sel, strobe, busy, done);
`else
  modport master (output start, dwell, input sel, strobe, busy, done);
  modport slave  (input start, dwell, output sel, strobe, busy, done);
`endif
endinterface

// File: rtl/demux_sel_sequencer.sv
// Walks the 1x8 demux select over the enabled channels, holding each for dwell+1 cycles.
// DEMUX_SEQ_MASK_EN enables the ch_mask input; otherwise every channel is visited.
module demux_sel_sequencer #(
  parameter int unsigned DWELL_W = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  demux_sel_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StDwell, StDone} state_e;

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [2:0]         sel_q, sel_d;
  logic [7:0]         mask_q, mask_d;
  logic [7:0]         mask_in;
  logic [2:0]         first_ch, next_ch;
  logic               next_found;

`ifdef DEMUX_SEQ_MASK_EN
  assign mask_in = bus.ch_mask;
`else
  assign mask_in = 8'hFF;
`endif

  // Lowest enabled channel of the incoming mask.
  always_comb begin
    first_ch = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask_in[i]) first_ch = 3'(i);
    end
  end

  // Lowest latched-enabled channel strictly above the current select; no wrap.
  always_comb begin
    next_ch    = 3'd0;
    next_found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!next_found && mask_q[i] && (i > int'(sel_q))) begin
        next_ch    = 3'(i);
        next_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          dwell_d = bus.dwell;
          mask_d  = mask_in;
          if (|mask_in) begin
            sel_d   = first_ch;
            cnt_d   = bus.dwell;
            state_d = StDwell;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDwell: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (next_found) begin
          sel_d = next_ch;
          cnt_d = dwell_q;
        end else begin
          sel_d   = 3'd0;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dwell_q <= '0;
      sel_q   <= 3'd0;
      mask_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
    end
  end

  // Outputs decode straight from registered state only.
  assign bus.sel    = sel_q;
  assign bus.strobe = (state_q == StDwell);
  assign bus.busy   = (state_q == StDwell);
  assign bus.done   = (state_q == StDone);

endmodule

// File: tb/tb_demux_sel_sequencer.sv
// Randomized/directed bench for demux_sel_sequencer against a per-cycle expected trace.
// Honours DEMUX_SEQ_MASK_EN the same way as the design.
module tb_demux_sel_sequencer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  // Expected per-cycle {sel, strobe, busy, done}.
  logic [5:0] exp_q[$];

  demux_sel_sequencer_if #(.DWELL_W(8)) bus ();

  demux_sel_sequencer #(.DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] observed();
    return {bus.sel, bus.strobe, bus.busy, bus.done};
  endfunction

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s got={sel,strobe,busy,done}=%b_%b expected=%b_%b",
             tag, got[5:3], got[2:0], want[5:3], want[2:0]);
    end
  endtask

  // Scan trace: each enabled channel ascending for d+1 strobe cycles, one done, then idle.
  task automatic build_exp(input logic [7:0] m, input int d);
    exp_q.delete();
    for (int ch = 0; ch < 8; ch++) begin
      if (m[ch]) begin
        for (int r = 0; r <= d; r++) exp_q.push_back({3'(ch), 3'b110});
      end
    end
    exp_q.push_back(6'b000_001);
    exp_q.push_back(6'b000_000);
  endtask

  // Issues a 1-cycle start, then checks every cycle of the scan. stop_after >= 0 returns early.
  task automatic run_scan(input string tag, input logic [7:0] m, input logic [7:0] d,
                          input bit interfere, input int stop_after);
    logic [7:0] eff;
`ifdef DEMUX_SEQ_MASK_EN
    eff = m;
`else
    eff = 8'hFF;
`endif
    build_exp(eff, int'(d));
    @(negedge clk);
    bus.start = 1'b1;
    bus.dwell = d;
`ifdef DEMUX_SEQ_MASK_EN
    bus.ch_mask = m;
`endif
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      check(tag, observed(), exp_q[i]);
      if (stop_after >= 0 && i == stop_after) begin
        bus.start = 1'b0;
        return;
      end
      if (interfere && exp_q[i][2:0] != 3'b000) begin
        bus.start = 1'($urandom_range(1, 0));
        bus.dwell = 8'($urandom);
`ifdef DEMUX_SEQ_MASK_EN
        bus.ch_mask = 8'($urandom);
`endif
      end else begin
        bus.start = 1'b0;
      end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.dwell = 8'd5;
`ifdef DEMUX_SEQ_MASK_EN
    bus.ch_mask = 8'hFF;
`endif

    // Reset held with start asserted: everything stays at reset values.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", observed(), 6'b000_000);
    end
    rst_n     = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    check("reset_idle", observed(), 6'b000_000);

    run_scan("full_d0", 8'hFF, 8'd0, 1'b0, -1);
`ifdef DEMUX_SEQ_MASK_EN
    run_scan("sparse_81", 8'h81, 8'd2, 1'b0, -1);
    run_scan("empty", 8'h00, 8'd3, 1'b0, -1);
    run_scan("dwell_max", 8'h80, 8'hFF, 1'b0, -1);
`else
    run_scan("dwell_max", 8'hFF, 8'hFF, 1'b0, -1);
`endif
    run_scan("full_d1", 8'hFF, 8'd1, 1'b0, -1);

    for (int n = 0; n < 8; n++) begin
      run_scan("rand_interf", 8'($urandom), 8'($urandom_range(5, 0)), 1'b1, -1);
    end

    // Async reset while on channel 3 (entries 12..15 with dwell 3).
    run_scan("pre_reset", 8'hFF, 8'd3, 1'b0, 13);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", observed(), 6'b000_000);
    @(negedge clk);
    check("reset_mid", observed(), 6'b000_000);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", observed(), 6'b000_000);
    run_scan("fresh_scan", 8'($urandom) | 8'h10, 8'd1, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
